xs_stream_merger: RTL and testbench
===================================

Name: xs_stream_merger

Overview:
Downstream consumer of the per-CPU xorshift output streams. Absorbs N_SRC free-running valid/data streams, which have no backpressure, into per-source FIFOs. Merges them round-robin onto one valid/ready output tagged with the source index. Keeps per-source delivered-word counts, raises done when every source reaches TARGET_CNT, and flags any source whose data was dropped.

Parameters:
N_SRC, 16, number of input streams (one per cpu instance)
DATA_W, 64, data width per word
FIFO_DEPTH, 4, entries per source FIFO (power of 2, >=2)
TARGET_CNT, 1000, delivered words per source required for done
CNT_W, 16, per-source counter width (2^CNT_W-1 >= TARGET_CNT)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_vld  in  N_SRC  per-source data valid; no ready, must be accepted or dropped
in_data  in  N_SRC*DATA_W  per-source data, source i at [i*DATA_W +: DATA_W]
out_vld  out  1  merged word valid
out_ready  in  1  downstream accept
out_data  out  DATA_W  merged word
out_src  out  $clog2(N_SRC)  source index of out_data
src_cnt  out  N_SRC*CNT_W  delivered-word count per source
ovf  out  N_SRC  sticky per-source overflow (word dropped)
done  out  1  sticky; all src_cnt >= TARGET_CNT

Behaviour:
- Reset (rst_n low, async): FIFOs empty; out_vld=0; out_data=0; out_src=0; src_cnt all 0; ovf=0; done=0; rr pointer=N_SRC-1, so source 0 has first priority.
- FIFO write: in_vld[i] pushes in_data[i] at the clock edge.
  - Full with no pop in the same cycle: word dropped, ovf[i] set and held until reset.
  - Full with a pop in the same cycle: write accepted, no overflow.
- Output register load condition: load = !out_vld || out_ready.
  - When load is true and any FIFO is non-empty, grant the first non-empty source scanning from rr+1 upward with wrap.
  - Pop the granted FIFO head into out_data/out_src, set out_vld=1, and set rr to the granted index.
  - When load is true and all FIFOs are empty, out_vld goes 0.
- out_vld/out_data/out_src hold stable while out_vld && !out_ready.
- Latency: a word sampled at edge t reaches the output at edge t+1 at the earliest (out_vld high the cycle after capture), provided the output register is free and the source is granted.
- Capacity per source with a stalled output: FIFO_DEPTH plus the output register.
- Order: words from the same source are delivered in arrival order. Across sources, round-robin applies only among non-empty FIFOs.
- src_cnt[out_src] increments on out_vld && out_ready and saturates at 2^CNT_W-1.
- done: registered; asserts the cycle after the handshake that makes the last source reach TARGET_CNT. Sticky until reset.
- Delivery after done continues normally; counts keep incrementing.
- Reset mid-operation: all buffered words are discarded, with no partial output. in_vld is ignored while rst_n is low.

Decomposition:
- Package xs_merge_pkg: SRC_W = $clog2(N_SRC) helper; function for round-robin next-grant (request vector, last grant -> grant index + valid).
- Sub-module xs_merge_fifo: single-clock synchronous FIFO with async active-low reset.
  - Ports: push, din, pop, dout, empty, full.
  - Simultaneous push+pop legal when full. Instantiated N_SRC times in a generate loop.
- Arbiter and counters stay in xs_stream_merger.

Test Plan:
- Single word, out_ready=1: in_vld[5]=1 with data 0xdeadbeefdeadbeef for one cycle -> out_vld=1 the next cycle with out_src=5 and that data; src_cnt[5]=1; ovf=0.
- Simultaneous burst, out_ready=1: all 16 in_vld high for one cycle with data=i -> 16 consecutive outputs with out_src 0,1,...,15 and data matching; no ovf.
- Stall overflow, out_ready=0: in_vld[3] high for 6 cycles -> 5 words buffered and ovf[3]=1 after the 6th edge. Then out_ready=1 -> exactly 5 words delivered in order, the 6th missing.
- Full with concurrent pop: FIFO 2 full, out reg holds a src-2 word, out_ready=1 and in_vld[2]=1 on the same cycle -> no ovf; all words delivered in order.
- Done, TARGET_CNT=3, N_SRC=4: each source sends 3 words with random out_ready -> done rises exactly one cycle after the 12th handshake; src_cnt all 3.
- Reset mid-stream: drop rst_n while FIFOs are partially full and out_vld=1 -> out_vld, src_cnt, ovf and done are 0 immediately (async). After release, the first new word is delivered normally from source 0 priority.

Source files
------------

// File: rtl/xs_merge_pkg.sv
// ============================================================================
// xs_merge_pkg : shared sizing helpers and round-robin grant function
// Revision: 1.0
// ============================================================================
`default_nettype none

package xs_merge_pkg;

  localparam int MAX_SRC   = 64;
  localparam int MAX_SRC_W = 6;

  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Scans from last+1 upward with wrap over n requesters; returns 1 on a hit.
  function automatic logic rr_next_grant(
    input  logic [MAX_SRC-1:0] req,
    input  int                 last,
    input  int                 n,
    output int                 idx
  );
    logic found;
    int   cand;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < MAX_SRC; k++) begin
      cand = last + 1 + k;
      if (cand >= n) cand = cand - n;
      if ((k < n) && !found && req[cand[MAX_SRC_W-1:0]]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return found;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xs_merge_fifo.sv
// ============================================================================
// xs_merge_fifo : single-clock FIFO, push while full is accepted only with pop
// Revision: 1.0
// ============================================================================
`default_nettype none

module xs_merge_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  // Extra pointer bit separates full from empty when the indices match.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout = mem_q[rd_ptr_q[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/xs_stream_merger.sv
// ============================================================================
// xs_stream_merger : buffers N_SRC free-running streams and merges them
//                    round-robin onto one valid/ready output with counters
// Revision: 1.0
// ============================================================================
`default_nettype none

module xs_stream_merger
  import xs_merge_pkg::*;
#(
  parameter int N_SRC      = 16,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int TARGET_CNT = 1000,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_SRC-1:0]        in_vld,
  input  logic [N_SRC*DATA_W-1:0] in_data,
  output logic                    out_vld,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [src_w(N_SRC)-1:0] out_src,
  output logic [N_SRC*CNT_W-1:0]  src_cnt,
  output logic [N_SRC-1:0]        ovf,
  output logic                    done
);

  localparam int SRC_W = src_w(N_SRC);

  logic [N_SRC-1:0]   fifo_empty, fifo_full, fifo_pop;
  logic [DATA_W-1:0]  fifo_dout [N_SRC];

  logic               out_vld_q, out_vld_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [SRC_W-1:0]   out_src_q, out_src_d;
  logic [SRC_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q [N_SRC];
  logic [CNT_W-1:0]   cnt_d [N_SRC];
  logic [N_SRC-1:0]   ovf_q, ovf_d;
  logic               done_q, done_d;

  logic               load;
  logic               grant_vld;
  int                 grant_idx;
  logic [SRC_W-1:0]   grant_src;
  logic [MAX_SRC-1:0] req;
  logic               all_hit;

  generate
    for (genvar i = 0; i < N_SRC; i++) begin : g_fifo
      xs_merge_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_vld[i]),
        .din   (in_data[i*DATA_W +: DATA_W]),
        .pop   (fifo_pop[i]),
        .dout  (fifo_dout[i]),
        .empty (fifo_empty[i]),
        .full  (fifo_full[i])
      );
    end
  endgenerate

  always_comb begin
    req              = '0;
    req[N_SRC-1:0]   = ~fifo_empty;
    load             = !out_vld_q || out_ready;
    grant_idx        = 0;
    grant_vld        = rr_next_grant(req, int'(rr_q), N_SRC, grant_idx);
    grant_src        = SRC_W'(grant_idx);
  end

  // Output register reloads whenever it is empty or being drained this cycle.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    rr_d       = rr_q;
    fifo_pop   = '0;
    if (load) begin
      out_vld_d = grant_vld;
      if (grant_vld) begin
        fifo_pop[grant_src] = 1'b1;
        out_data_d          = fifo_dout[grant_src];
        out_src_d           = grant_src;
        rr_d                = grant_src;
      end
    end
  end

  always_comb begin
    all_hit = 1'b1;
    for (int i = 0; i < N_SRC; i++) begin
      cnt_d[i] = cnt_q[i];
      if (out_vld_q && out_ready && (out_src_q == SRC_W'(i)) && (cnt_q[i] != '1))
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      if (cnt_d[i] < CNT_W'(TARGET_CNT)) all_hit = 1'b0;
      ovf_d[i] = ovf_q[i] | (in_vld[i] & fifo_full[i] & ~fifo_pop[i]);
    end
    // Judged on next-state counts so done rises right after the final handshake.
    done_d = done_q | all_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_src_q  <= '0;
      rr_q       <= SRC_W'(N_SRC - 1);
      ovf_q      <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < N_SRC; i++) cnt_q[i] <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
      rr_q       <= rr_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      for (int i = 0; i < N_SRC; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  generate
    for (genvar i = 0; i < N_SRC; i++) begin : g_cnt_out
      assign src_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  endgenerate

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_src  = out_src_q;
  assign ovf      = ovf_q;
  assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_xs_stream_merger.sv
// ============================================================================
// tb_xs_stream_merger : directed checks on a 16-source and a 4-source merger
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_xs_stream_merger;

  logic           clk;
  logic           rst_n;

  logic [15:0]    b_in_vld;
  logic [1023:0]  b_in_data;
  logic           b_out_vld, b_out_ready;
  logic [63:0]    b_out_data;
  logic [3:0]     b_out_src;
  logic [255:0]   b_src_cnt;
  logic [15:0]    b_ovf;
  logic           b_done;

  logic [3:0]     s_in_vld;
  logic [63:0]    s_in_data;
  logic           s_out_vld, s_out_ready;
  logic [15:0]    s_out_data;
  logic [1:0]     s_out_src;
  logic [15:0]    s_src_cnt;
  logic [3:0]     s_ovf;
  logic           s_done;

  int n_vec = 0;
  int n_err = 0;

  xs_stream_merger #(
    .N_SRC(16), .DATA_W(64), .FIFO_DEPTH(4), .TARGET_CNT(1000), .CNT_W(16)
  ) u_big (
    .clk(clk), .rst_n(rst_n), .in_vld(b_in_vld), .in_data(b_in_data),
    .out_vld(b_out_vld), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_src(b_out_src), .src_cnt(b_src_cnt), .ovf(b_ovf), .done(b_done)
  );

  xs_stream_merger #(
    .N_SRC(4), .DATA_W(16), .FIFO_DEPTH(4), .TARGET_CNT(3), .CNT_W(4)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .in_vld(s_in_vld), .in_data(s_in_data),
    .out_vld(s_out_vld), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_src(s_out_src), .src_cnt(s_src_cnt), .ovf(s_ovf), .done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    b_in_vld = '0;
    s_in_vld = '0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] bcnt(input int i);
    return b_src_cnt[i*16 +: 16];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hs_cnt;
    logic hs;
    rst_n       = 1'b0;
    b_in_vld    = '0;
    b_in_data   = '0;
    b_out_ready = 1'b0;
    s_in_vld    = '0;
    s_in_data   = '0;
    s_out_ready = 1'b0;
    do_reset;

    chk("rst_vld",  b_out_vld, 0);
    chk("rst_data", b_out_data, 0);
    chk("rst_src",  b_out_src, 0);
    chk("rst_cnt",  |b_src_cnt, 0);
    chk("rst_ovf",  b_ovf, 0);
    chk("rst_done", b_done, 0);

    // Single word from source 5
    b_out_ready = 1'b1;
    b_in_vld[5] = 1'b1;
    b_in_data[5*64 +: 64] = 64'hdeadbeefdeadbeef;
    tick;
    b_in_vld = '0;
    chk("t1_not_yet", b_out_vld, 0);
    tick;
    chk("t1_vld",  b_out_vld, 1);
    chk("t1_src",  b_out_src, 5);
    chk("t1_data", b_out_data, 64'hdeadbeefdeadbeef);
    tick;
    chk("t1_cnt5", bcnt(5), 1);
    chk("t1_idle", b_out_vld, 0);
    chk("t1_ovf",  b_ovf, 0);

    // All sources at once, delivered 0..15
    do_reset;
    b_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) b_in_data[i*64 +: 64] = 64'(i);
    b_in_vld = '1;
    tick;
    b_in_vld = '0;
    for (int k = 0; k < 16; k++) begin
      tick;
      chk("t2_vld",  b_out_vld, 1);
      chk("t2_src",  b_out_src, 64'(k));
      chk("t2_data", b_out_data, 64'(k));
    end
    tick;
    chk("t2_idle", b_out_vld, 0);
    chk("t2_ovf",  b_ovf, 0);
    chk("t2_cnt15", bcnt(15), 1);

    // Stalled output, source 3 overflows on the 6th word
    do_reset;
    b_out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      b_in_vld[3] = 1'b1;
      b_in_data[3*64 +: 64] = 64'h300 + 64'(k);
      tick;
      if (k == 4) chk("t3_ovf_5th", b_ovf, 0);
    end
    b_in_vld = '0;
    chk("t3_ovf_6th", b_ovf, 16'h0008);
    b_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("t3_vld",  b_out_vld, 1);
      chk("t3_data", b_out_data, 64'h300 + 64'(k));
      tick;
    end
    chk("t3_no_6th", b_out_vld, 0);
    chk("t3_cnt3",   bcnt(3), 5);
    chk("t3_sticky", b_ovf, 16'h0008);

    // Full FIFO with a concurrent pop
    do_reset;
    b_out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      b_in_vld[2] = 1'b1;
      b_in_data[2*64 +: 64] = 64'h200 + 64'(k);
      tick;
    end
    chk("t4_head", b_out_data, 64'h200);
    b_out_ready = 1'b1;
    b_in_data[2*64 +: 64] = 64'h205;
    tick;
    b_in_vld = '0;
    chk("t4_ovf", b_ovf, 0);
    for (int k = 1; k < 6; k++) begin
      chk("t4_vld",  b_out_vld, 1);
      chk("t4_data", b_out_data, 64'h200 + 64'(k));
      tick;
    end
    chk("t4_idle", b_out_vld, 0);
    chk("t4_cnt2", bcnt(2), 6);

    // Done on the 4-source instance with random backpressure
    do_reset;
    hs_cnt = 0;
    for (int cyc = 0; cyc < 400 && hs_cnt < 12; cyc++) begin
      s_in_vld = (cyc < 3) ? 4'hf : 4'h0;
      for (int s = 0; s < 4; s++) s_in_data[s*16 +: 16] = 16'(s*16 + cyc);
      s_out_ready = 1'($urandom_range(0, 1));
      hs = s_out_vld && s_out_ready;
      if (hs) begin
        chk("t5_src",  s_out_src, 64'(hs_cnt % 4));
        chk("t5_data", s_out_data, 64'((hs_cnt % 4) * 16 + hs_cnt / 4));
      end
      tick;
      if (hs) hs_cnt++;
      chk("t5_done", s_done, (hs_cnt >= 12) ? 1 : 0);
    end
    s_in_vld = '0;
    chk("t5_hs_total", 64'(hs_cnt), 12);
    for (int s = 0; s < 4; s++) chk("t5_cnt", s_src_cnt[s*4 +: 4], 3);
    chk("t5_ovf", s_ovf, 0);
    s_out_ready = 1'b0;
    tick;
    chk("t5_sticky", s_done, 1);

    // Asynchronous reset while words are buffered
    b_out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      b_in_vld = 16'h000a;
      b_in_data[1*64 +: 64] = 64'h110 + 64'(k);
      b_in_data[3*64 +: 64] = 64'h330 + 64'(k);
      tick;
    end
    chk("t6_pre_ovf", b_ovf, 16'h000a);
    chk("t6_pre_vld", b_out_vld, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_vld",  b_out_vld, 0);
    chk("t6_async_cnt",  |b_src_cnt, 0);
    chk("t6_async_ovf",  b_ovf, 0);
    chk("t6_async_done", s_done, 0);
    chk("t6_async_data", b_out_data, 0);
    tick;
    tick;
    b_in_vld = '0;
    rst_n    = 1'b1;
    tick;
    chk("t6_post_idle", b_out_vld, 0);
    b_out_ready = 1'b1;
    b_in_vld = 16'h1001;
    b_in_data[0*64 +: 64]  = 64'ha0;
    b_in_data[12*64 +: 64] = 64'hac;
    tick;
    b_in_vld = '0;
    tick;
    chk("t6_first_src",  b_out_src, 0);
    chk("t6_first_data", b_out_data, 64'ha0);
    tick;
    chk("t6_second_src",  b_out_src, 12);
    chk("t6_second_data", b_out_data, 64'hac);
    tick;
    chk("t6_idle", b_out_vld, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
